// File: rtl/wb_ram_slave_if.sv
// wb_ram_slave_if: Wishbone classic data bus between the CPU data master and the RAM responder.
// Master drives wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i (byte address), wb_sel_i (big-endian lanes), wb_dat_i.
// Slave drives wb_dat_o (registered read data), wb_ack_o and wb_err_o (single-cycle pulses).
interface wb_ram_slave_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone classic single-port 32-bit data RAM responder with fixed wait states.
// Ports: clk (rising edge), rst (asynchronous, active-low), bus (wb_ram_slave_if.slave).
// Parameters: DEPTH_LOG2 (RAM depth 2**DEPTH_LOG2 words), WAIT_STATES (0..15 cycles between accept and ack).
// Macro WB_ADDR_CHECK_EN: when defined, out-of-range or unaligned addresses answer with err_o instead of ack_o;
// when undefined, addresses alias modulo the RAM size and err_o stays 0.
module wb_ram_slave #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input logic           clk,
  input logic           rst,
  wb_ram_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  logic [31:0] mem [2**DEPTH_LOG2];
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, sel_q, sel_d, cur_sel;
  logic [31:0] adr_q, adr_d, wdat_q, wdat_d, dat_q, dat_d, cur_adr, cur_dat;
  logic        we_q, we_d, ack_q, ack_d, err_q, err_d, cur_we;
  logic        idle, req, go_resp, bad, wr_en;
  logic [DEPTH_LOG2-1:0] idx;
  assign idle = state_q == IDLE;
  assign req  = bus.wb_cyc_i && bus.wb_stb_i;
  // With no wait states the response happens on the accepting edge, before anything is latched.
  assign cur_adr = idle ? bus.wb_adr_i : adr_q;
  assign cur_dat = idle ? bus.wb_dat_i : wdat_q;
  assign cur_sel = idle ? bus.wb_sel_i : sel_q;
  assign cur_we  = idle ? bus.wb_we_i  : we_q;
  assign idx     = cur_adr[DEPTH_LOG2+1:2];
`ifdef WB_ADDR_CHECK_EN
  assign bad = (|cur_adr[31:DEPTH_LOG2+2]) || (|cur_adr[1:0]);
`else
  logic unused_adr;
  assign bad        = 1'b0;
  assign unused_adr = ^{cur_adr[31:DEPTH_LOG2+2], cur_adr[1:0]};
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    if (idle && req) begin
      adr_d   = bus.wb_adr_i;
      wdat_d  = bus.wb_dat_i;
      sel_d   = bus.wb_sel_i;
      we_d    = bus.wb_we_i;
      state_d = WAIT_STATES == 0 ? RESP : WAIT;
      cnt_d   = CNT_INIT;
    end else if (state_q == WAIT) begin
      // Dropping cyc during the wait abandons the transfer silently.
      state_d = !bus.wb_cyc_i ? IDLE : cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = (bus.wb_cyc_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    go_resp = state_d == RESP;
    wr_en   = go_resp && cur_we && !bad;
    ack_d   = go_resp && !bad;
    err_d   = go_resp && bad;
    dat_d   = (go_resp && bad) ? '0 : (go_resp && !cur_we) ? mem[idx] : dat_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  // Memory is deliberately left unreset; sel[3] maps to bits 31:24 (byte offset 0, big-endian).
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (cur_sel[b]) mem[idx][8*b +: 8] <= cur_dat[8*b +: 8];
  end
  assign bus.wb_dat_o = dat_q;
  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone classic single-port data RAM responder for the OpenMIPS minimal SOPC. The CPU's data bus master initiates transfers and this block services them. Each transfer can be held off by a fixed number of wait states, so the pipeline's stall path is exercised in simulation. The block sits beside the instruction ROM in the SOPC top and is driven in simulation by the SOPC testbench clock and reset.

## Interface
Parameters:
- DEPTH_LOG2, 10: RAM depth in 32-bit words (2**DEPTH_LOG2).
- WAIT_STATES, 1: extra cycles inserted between accept and ack; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Asserted when 0.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; a transfer is requested when cyc and stb are both 1.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte lane selects. Big-endian: sel[3] selects dat[31:24], which is the byte at address offset 0.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; registered.
- wb_ack_o  out  1  transfer done; a single-cycle pulse.
- wb_err_o  out  1  transfer error; a single-cycle pulse. Tied 0 unless the macro is defined.

## Operation
- The FSM has three states: IDLE, WAIT and RESP. Reset puts it in IDLE.
- IDLE: at a clock edge with cyc&stb=1, latch adr, we, sel and dat_i (this is the accepting edge e0).
  - WAIT_STATES=0: go to RESP.
  - Otherwise: go to WAIT and load the counter with WAIT_STATES-1.
- WAIT: at each edge, if cyc=0, abort. An abort returns to IDLE with no write, no ack and no err.
  - Else if the counter is 0, go to RESP.
  - Else decrement the counter.
- Edge entering RESP:
  - Write: update each byte lane whose sel bit is 1; unselected lanes are unchanged.
  - Read: load dat_o with mem[word index]. sel is ignored on reads, and all 32 bits are returned.
- RESP: ack_o (or err_o) is 1 for this single cycle. The next state is IDLE unconditionally.
  - A new request is sampled only from IDLE, so a master that holds stb for exactly the ack cycle is never double-accepted.
- Word index is wb_adr_i[DEPTH_LOG2+1:2].
- Inputs other than cyc are ignored after e0; the latched copies are used.
- dat_o holds its last value outside RESP.
- Memory contents are not reset. After reset, reads of unwritten words return X in simulation.

## Timing
- Reset values: dat_o=0, ack_o=0, err_o=0, state=IDLE, counter=0.
- Reset asserted mid-transfer: the FSM goes to IDLE immediately and no ack/err is produced. If the write edge has not occurred, memory is unchanged.
- Latency: ack is high in the cycle after edge e0+WAIT_STATES. Request to ack is WAIT_STATES+1 edges.
- Throughput: at most one transfer per WAIT_STATES+2 cycles.
- ack_o and err_o are never both 1. Neither is ever high for two consecutive cycles.
- Simultaneous read and write to the same word are impossible; there is a single port and one transfer at a time.

## Configuration
- Macro WB_ADDR_CHECK_EN.
- Defined: a transfer is an error if wb_adr_i[31:DEPTH_LOG2+2]≠0 or wb_adr_i[1:0]≠0.
  - An error transfer asserts err_o instead of ack_o, at the same cycle as ack would.
  - No memory write occurs, and dat_o is loaded with 0.
- Undefined: upper address bits and bits [1:0] are ignored, so addresses alias modulo the RAM size. err_o is tied 0.

## Test plan
- WAIT_STATES=2: write 0x12345678, sel=4'hF, to 0x10, then read 0x10.
  - Required: ack in the cycle after e0+2 for each transfer and dat_o=0x12345678 during the read ack.
- Byte write: sel=4'b0100, dat_i=0x00AB0000 to 0x10, then read.
  - Required: 0x12AB5678.
- Abort: a write of 0xFFFFFFFF to 0x10 with cyc dropped during WAIT.
  - Required: no ack, and a subsequent read returns 0x12AB5678.
- Reset: assert rst=0 for 1 cycle in WAIT.
  - Required: ack/err/dat_o go to 0 asynchronously and the FSM is in IDLE. The next request completes with normal latency.
- WAIT_STATES=0 with stb held for two back-to-back transfers.
  - Required: ack pulses 2 cycles apart and never on consecutive cycles.
- WB_ADDR_CHECK_EN defined, DEPTH_LOG2=10: write to 0x00001000 and to 0x00000002.
  - Required: err_o pulse each, and ack_o=0.
  - A read of word 0 afterwards is unchanged.
  - Without the macro, the write to 0x1000 aliases to word 0.
